// File: rtl/seq_shift_add_multiplier.sv
// Unsigned sequential shift-add multiplier.
// An operand pair is captured on an accepted Start. The datapath then runs one
// add/shift iteration per clock for WIDTH clocks. The 2*WIDTH-bit product is
// loaded on the last iteration and announced by a one-cycle Done strobe.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic [2*WIDTH-1:0] Product,
  output logic               Busy,
  output logic               Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d;        // partial-product high half plus carry
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;  // low product bits shift in from the top
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     acc_sh;
  logic [WIDTH-1:0]   mplier_sh;
  logic               last_iter;

  // The final iteration is the one where the counter has reached WIDTH-1.
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // One iteration: conditional add of the multiplicand, then a logical right
  // shift of {sum, mplier}. The carry of the add lands in bit WIDTH-1 of the
  // accumulator, so no product bit is ever lost.
  always_comb begin
    sum       = {1'b0, acc_q[WIDTH-1:0]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_sh    = {1'b0, sum[WIDTH:1]};
    mplier_sh = {sum[0], mplier_q[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. An unused encoding falls back to IDLE.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = Start ? S_RUN : S_IDLE;
      S_RUN:   state_d = last_iter ? S_DONE : S_RUN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state alone. Start has no effect on them.
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (state_q)
      S_RUN:   Busy = 1'b1;
      S_DONE:  begin Busy = 1'b1; Done = 1'b1; end
      default: ;
    endcase
  end

  // Datapath next-state. Operands are captured only when Start is accepted in
  // IDLE. The product register changes only on the last iteration.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          acc_d    = '0;
          mcand_d  = Multiplicand;
          mplier_d = Multiplier;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        acc_d    = acc_sh;
        mplier_d = mplier_sh;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) prod_d = {acc_sh[WIDTH-1:0], mplier_sh};
      end
      S_DONE: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Datapath registers. Reset clears everything, including a held product.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

  assign Product = prod_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier (WIDTH=8). Inputs are driven and
// outputs sampled on the falling edge of the clock.
module tb_seq_shift_add_multiplier;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [7:0]  Multiplicand;
  logic [7:0]  Multiplier;
  logic [15:0] Product;
  logic        Busy;
  logic        Done;

  int errors = 0;
  int checks = 0;

  seq_shift_add_multiplier #(.WIDTH(8), .CNT_W(4)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Product      (Product),
    .Busy         (Busy),
    .Done         (Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait on falling edges until Done. n counts falling edges since the
  // accepting edge, and the first falling edge after that edge is 1. The wait
  // gives up after 20.
  task automatic wait_done(output int n);
    n = 1;
    while (!Done && n < 20) begin
      @(negedge Clk);
      n++;
    end
  endtask

  // Accept one operation and check latency, Busy and the result.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    int n;
    @(negedge Clk);
    Start = 1'b1; Multiplicand = a; Multiplier = b;
    @(negedge Clk);
    Start = 1'b0;
    check({tag, "_busy"}, Busy, 1);
    wait_done(n);
    check({tag, "_lat"}, n, 9);
    check({tag, "_prod"}, Product, exp);
    @(negedge Clk);
    check({tag, "_idle"}, {Busy, Done}, 2'b00);
    check({tag, "_hold"}, Product, exp);
  endtask

  initial begin
    int n, dcnt;
    logic unstable;
    Reset = 1'b1; Start = 1'b0; Multiplicand = '0; Multiplier = '0;
    #12;
    check("rst_prod", Product, 16'h0000);
    check("rst_flags", {Busy, Done}, 2'b00);
    @(negedge Clk);
    Reset = 1'b0;

    // Basic products, including the carry path and a zero operand.
    run_op("m13x11", 8'd13, 8'd11, 16'h008F);
    run_op("mffxff", 8'hFF, 8'hFF, 16'hFE01);
    run_op("m00xff", 8'h00, 8'hFF, 16'h0000);
    run_op("m01x01", 8'h01, 8'h01, 16'h0001);

    // Busy stays high for exactly 9 cycles.
    @(negedge Clk);
    Start = 1'b1; Multiplicand = 8'd5; Multiplier = 8'd6;
    @(negedge Clk);
    Start = 1'b0;
    n = 0;
    while (Busy && n < 20) begin
      n++;
      @(negedge Clk);
    end
    check("busy_len", n, 9);
    check("busy_prod", Product, 16'd30);

    // Hold Start high and change the operands in mid-run. Only one Done is
    // expected, with the result of the captured operands, and the next accept
    // happens only after IDLE.
    @(negedge Clk);
    Start = 1'b1; Multiplicand = 8'd6; Multiplier = 8'd7;
    @(negedge Clk);
    Multiplicand = 8'hFF; Multiplier = 8'hFF;
    dcnt = 0;
    for (int i = 1; i <= 10; i++) begin
      if (Done) begin
        dcnt++;
        check("hold_prod", Product, 16'd42);
      end
      if (i == 10) check("hold_idle", Busy, 0);
      if (i < 10) @(negedge Clk);
    end
    check("hold_done_cnt", dcnt, 1);
    @(negedge Clk);
    Start = 1'b0;
    check("hold_reaccept", Busy, 1);
    wait_done(n);
    check("hold_lat2", n, 9);
    check("hold_prod2", Product, 16'hFE01);
    @(negedge Clk);

    // Assert an asynchronous reset in mid-cycle during iteration 4 of 200*100.
    // The outputs must clear before the next clock edge.
    @(negedge Clk);
    Start = 1'b1; Multiplicand = 8'd200; Multiplier = 8'd100;
    @(posedge Clk);
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("arst_prod", Product, 16'h0000);
    check("arst_flags", {Busy, Done}, 2'b00);
    @(negedge Clk);
    Reset = 1'b0;
    run_op("m200x100", 8'd200, 8'd100, 16'h4E20);

    // Back to back: restart in the cycle after Done. The first product must
    // stay stable until the second load.
    @(negedge Clk);
    Start = 1'b1; Multiplicand = 8'd3; Multiplier = 8'd5;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(n);
    check("b2b_lat1", n, 9);
    check("b2b_prod1", Product, 16'd15);
    @(negedge Clk);
    Start = 1'b1; Multiplicand = 8'd7; Multiplier = 8'd9;
    @(negedge Clk);
    Start = 1'b0;
    check("b2b_busy2", Busy, 1);
    unstable = 1'b0;
    n = 1;
    while (!Done && n < 20) begin
      if (Product !== 16'd15) unstable = 1'b1;
      @(negedge Clk);
      n++;
    end
    check("b2b_stable", unstable, 0);
    check("b2b_lat2", n, 9);
    check("b2b_prod2", Product, 16'd63);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
